mic_arb_mem: RTL and testbench

Second-generation memory interface controller. Accepts read and write requests from NREQS requesters, each into its own request FIFO of depth RDEPTH, and arbitrates one request per cycle into a shared single-port memory of MDEPTH words. The arbiter runs in round-robin or fixed-priority mode, selected by parameter. Read data returns tagged with the requester ID. Optional partition protection confines each requester to its own PSIZE-word region.

---
 rtl/mic_pkg.sv | 23 ++
 rtl/mic_req_fifo.sv | 56 +++++
 rtl/mic_arb_mem.sv | 137 +++++++++++++
 tb/tb_mic_arb_mem.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared types and constants for the mic_arb_mem controller
package mic_pkg;

    typedef enum logic [1:0] {
        MIC_NOP   = 2'b00,
        MIC_READ  = 2'b01,
        MIC_WRITE = 2'b10,
        MIC_RSVD  = 2'b11
    } mic_op_e;

    localparam int MIC_AWIDTH = 8;
    localparam int MIC_MWIDTH = 32;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef struct packed {
        mic_op_e                 op;
        logic [MIC_AWIDTH-1:0]   addr;
        logic [MIC_MWIDTH-1:0]   wdata;
    } mic_req_t;

endpackage

// File: rtl/mic_req_fifo.sv
// rtl/mic_req_fifo.sv - per-requester request FIFO, power-of-2 depth
module mic_req_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PBITS = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [0:DEPTH-1];
    logic [PBITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PBITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PBITS:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign full    = (count_q == (PBITS+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = storage[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PBITS'(push_ok);
        rd_ptr_d = rd_ptr_q + PBITS'(pop_ok);
        count_d  = count_q + (PBITS+1)'(push_ok) - (PBITS+1)'(pop_ok);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            storage[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mic_arb_mem.sv
// rtl/mic_arb_mem.sv - arbitrates NREQS request FIFOs onto one single-port memory
module mic_arb_mem
    import mic_pkg::*;
#(
    parameter int NREQS    = 4,
    parameter int PSIZE    = 64,
    parameter int MDEPTH   = NREQS * PSIZE,
    parameter int AWIDTH   = $clog2(MDEPTH),
    parameter int MWIDTH   = 32,
    parameter int RWIDTH   = AWIDTH + MWIDTH + 2,
    parameter int RDEPTH   = 4,
    parameter int RBITS    = $clog2(NREQS),
    parameter int ARB_MODE = ARB_RR,
    parameter int PROTECT  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQS-1:0]  req_valid,
    input  logic [RWIDTH-1:0] req_data [0:NREQS-1],
    output logic [NREQS-1:0]  fifo_full,
    output logic [NREQS-1:0]  read_valid,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [MWIDTH-1:0] mem_rdata,
    output logic              rdata_valid,
    output logic [RBITS-1:0]  rdata_id,
    output logic [NREQS-1:0]  access_err
);
    localparam int CBITS = $clog2(RDEPTH) + 1;

    logic [NREQS-1:0]  fifo_empty;
    logic [RWIDTH-1:0] fifo_rdata [0:NREQS-1];
    logic [CBITS-1:0]  fifo_count_unused [0:NREQS-1];
    logic [NREQS-1:0]  pop;

    logic              gnt_valid;
    logic [RBITS-1:0]  gnt_idx;
    logic [RWIDTH-1:0] head;
    mic_op_e           head_op;
    logic [AWIDTH-1:0] head_addr;
    logic [MWIDTH-1:0] head_wdata;
    logic              legal, do_read, do_write, do_err;

    logic [MWIDTH-1:0] mem [0:MDEPTH-1];

    logic [RBITS-1:0]  ptr_q, ptr_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MWIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic [RBITS-1:0]  rdata_id_q, rdata_id_d;
    logic [NREQS-1:0]  access_err_q, access_err_d;

    for (genvar i = 0; i < NREQS; i++) begin : g_fifo
        mic_req_fifo #(.WIDTH(RWIDTH), .DEPTH(RDEPTH)) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (req_valid[i]),
            .pop   (pop[i]),
            .wdata (req_data[i]),
            .rdata (fifo_rdata[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .count (fifo_count_unused[i])
        );
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = NREQS - 1; i >= 0; i--) begin
                if (!fifo_empty[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = RBITS'(i);
                end
            end
        end else begin
            // Scan the rotation backwards so the first hit after ptr is the last one written.
            for (int k = NREQS; k >= 1; k--) begin
                if (!fifo_empty[(int'(ptr_q) + k) % NREQS]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = RBITS'((int'(ptr_q) + k) % NREQS);
                end
            end
        end
    end

    assign head       = fifo_rdata[gnt_idx];
    assign head_op    = mic_op_e'(head[RWIDTH-1 -: 2]);
    assign head_addr  = head[MWIDTH +: AWIDTH];
    assign head_wdata = head[MWIDTH-1:0];
    assign legal      = (PROTECT == 0) || (head_addr[AWIDTH-1 -: RBITS] == gnt_idx);
    assign do_read    = gnt_valid && legal && (head_op == MIC_READ);
    assign do_write   = gnt_valid && legal && (head_op == MIC_WRITE);
    assign do_err     = gnt_valid && !legal && (head_op == MIC_READ || head_op == MIC_WRITE);
    assign pop        = gnt_valid ? (NREQS'(1) << gnt_idx) : '0;
    assign read_valid = do_read ? (NREQS'(1) << gnt_idx) : '0;

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[head_addr] <= head_wdata;
        end
    end

    always_comb begin
        ptr_d         = gnt_valid ? gnt_idx : ptr_q;
        mem_addr_d    = (do_read || do_write) ? head_addr : mem_addr_q;
        mem_rdata_d   = do_read ? mem[head_addr] : mem_rdata_q;
        rdata_valid_d = do_read;
        rdata_id_d    = do_read ? gnt_idx : rdata_id_q;
        access_err_d  = do_err ? (NREQS'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q         <= RBITS'(NREQS - 1);
            mem_addr_q    <= '0;
            mem_rdata_q   <= '0;
            rdata_valid_q <= 1'b0;
            rdata_id_q    <= '0;
            access_err_q  <= '0;
        end else begin
            ptr_q         <= ptr_d;
            mem_addr_q    <= mem_addr_d;
            mem_rdata_q   <= mem_rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_id_q    <= rdata_id_d;
            access_err_q  <= access_err_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rdata   = mem_rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_id    = rdata_id_q;
    assign access_err  = access_err_q;

endmodule

// File: tb/tb_mic_arb_mem.sv
// tb/tb_mic_arb_mem.sv - scoreboard bench: round-robin, fixed-priority and protected instances
module tb_mic_arb_mem;
    import mic_pkg::*;

    localparam int N  = 4;
    localparam int NI = 3;
    localparam logic [31:0] DAT [4] = '{32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333};
    localparam logic [7:0]  ADR [4] = '{8'h05, 8'h45, 8'h85, 8'hC5};

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [41:0]   req_data [0:N-1];
    logic [N-1:0]  full  [NI];
    logic [N-1:0]  rv    [NI];
    logic [7:0]    maddr [NI];
    logic [31:0]   rdata [NI];
    logic          rdv   [NI];
    logic [1:0]    rid   [NI];
    logic [N-1:0]  aerr  [NI];

    typedef struct packed {
        logic        err;
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q  [NI][$];
    int   gnt_q [NI][$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    // Instance 0: round-robin, 1: fixed priority, 2: round-robin with partition protection
    for (genvar d = 0; d < NI; d++) begin : g_dut
        mic_arb_mem #(
            .ARB_MODE (d == 1 ? ARB_FIXED : ARB_RR),
            .PROTECT  (d == 2 ? 1 : 0)
        ) u_dut (
            .clock       (clock),
            .reset       (reset),
            .req_valid   (req_valid),
            .req_data    (req_data),
            .fifo_full   (full[d]),
            .read_valid  (rv[d]),
            .mem_addr    (maddr[d]),
            .mem_rdata   (rdata[d]),
            .rdata_valid (rdv[d]),
            .rdata_id    (rid[d]),
            .access_err  (aerr[d])
        );
    end

    function automatic void check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic exp_gnt(input int d, input int id);
        gnt_q[d].push_back(id);
    endtask

    task automatic exp_rd(input int d, input int id, input logic [31:0] data);
        exp_t e;
        e.err  = 1'b0;
        e.id   = 2'(id);
        e.data = data;
        gnt_q[d].push_back(id);
        sb_q[d].push_back(e);
    endtask

    task automatic exp_err(input int d, input int id);
        exp_t e;
        e.err  = 1'b1;
        e.id   = 2'(id);
        e.data = '0;
        sb_q[d].push_back(e);
    endtask

    task automatic put(input int i, input mic_op_e op, input logic [7:0] a, input logic [31:0] w);
        mic_req_t r;
        r.op        = op;
        r.addr      = a;
        r.wdata     = w;
        req_data[i] = r;
        req_valid[i] = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            req_valid = '0;
        end
    endtask

    // Monitor: pops scoreboard entries whenever an instance presents a grant, read data or error.
    int   g;
    exp_t e;
    always @(negedge clock) begin
        if (!reset) begin
            for (int d = 0; d < NI; d++) begin
                if (rv[d] != '0) begin
                    if (gnt_q[d].size() == 0) begin
                        check(1'b0, $sformatf("grant_unexpected[%0d]", d), 64'(rv[d]), 64'(0));
                    end else begin
                        g = gnt_q[d].pop_front();
                        check(rv[d] == 4'(1 << g), $sformatf("grant[%0d]", d), 64'(rv[d]), 64'(4'(1 << g)));
                    end
                end
                if (rdv[d] || aerr[d] != '0) begin
                    if (sb_q[d].size() == 0) begin
                        check(1'b0, $sformatf("resp_unexpected[%0d]", d), {28'(0), aerr[d], rid[d], rdata[d]}, 64'(0));
                    end else begin
                        e = sb_q[d].pop_front();
                        if (e.err) begin
                            check(!rdv[d] && aerr[d] == 4'(1 << e.id), $sformatf("access_err[%0d]", d),
                                  {31'(0), rdv[d], 28'(0), aerr[d]}, 64'(4'(1 << e.id)));
                        end else begin
                            check(aerr[d] == '0 && rid[d] == e.id && rdata[d] == e.data, $sformatf("rdata[%0d]", d),
                                  {26'(0), aerr[d], rid[d], rdata[d]}, {30'(0), e.id, e.data});
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) req_data[i] = '0;
        #12;
        for (int d = 0; d < NI; d++) begin
            check(full[d] == 0 && rv[d] == 0 && aerr[d] == 0 && !rdv[d] && rid[d] == 0 && maddr[d] == 0 && rdata[d] == 0,
                  $sformatf("reset_state[%0d]", d), {24'(0), maddr[d], rdata[d]}, 64'(0));
        end
        reset = 1'b0;
        tick(1);

        // Write then read back from requester 0, checking read latency
        for (int d = 0; d < NI; d++) exp_rd(d, 0, 32'hDEADBEEF);
        put(0, MIC_WRITE, 8'h05, 32'hDEADBEEF);
        tick(1);
        put(0, MIC_READ, 8'h05, 32'h0);
        tick(1);
        @(posedge clock);
        #1;
        for (int d = 0; d < NI; d++) begin
            check(rdv[d] && rdata[d] == 32'hDEADBEEF && rid[d] == 0, $sformatf("latency[%0d]", d),
                  {31'(0), rdv[d], rdata[d]}, {32'(1), 32'hDEADBEEF});
            check(maddr[d] == 8'h05, $sformatf("mem_addr_a[%0d]", d), 64'(maddr[d]), 64'(8'h05));
        end
        tick(3);

        // Seed the other partitions; requester 2 is granted last so RR ptr ends at 2
        put(0, MIC_WRITE, 8'h10, 32'h0000AAAA); tick(3);
        put(1, MIC_WRITE, 8'h45, DAT[1]);       tick(3);
        put(3, MIC_WRITE, 8'hC5, DAT[3]);       tick(3);
        put(2, MIC_WRITE, 8'h85, DAT[2]);       tick(3);

        // Requester 2 overfills while the others stay busy
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                exp_rd(0, (k + 3) % 4, DAT[(k + 3) % 4]);
                exp_rd(2, (k + 3) % 4, DAT[(k + 3) % 4]);
                exp_rd(1, r, DAT[r]);
            end
        end
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < N; i++) put(i, MIC_READ, ADR[i], 32'h0);
            tick(1);
        end
        for (int d = 0; d < NI; d++) begin
            check(full[d] == (d == 1 ? 4'b1110 : 4'b0100), $sformatf("fifo_full[%0d]", d),
                  64'(full[d]), 64'(d == 1 ? 4'b1110 : 4'b0100));
        end
        put(2, MIC_READ, 8'h85, 32'h0);
        tick(1);
        tick(20);
        for (int d = 0; d < NI; d++) begin
            check(maddr[d] == (d == 1 ? 8'hC5 : 8'h85), $sformatf("mem_addr_b[%0d]", d),
                  64'(maddr[d]), 64'(d == 1 ? 8'hC5 : 8'h85));
        end

        // Two reads per FIFO; requester 3 is granted first so RR starts at 0
        put(3, MIC_WRITE, 8'hC5, DAT[3]);
        tick(3);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                exp_rd(0, k, DAT[k]);
                exp_rd(2, k, DAT[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            exp_rd(1, k, DAT[k]);
            exp_rd(1, k, DAT[k]);
        end
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < N; i++) put(i, MIC_READ, ADR[i], 32'h0);
            tick(1);
        end
        tick(12);

        // Cross-partition write from requester 1
        exp_err(2, 1);
        put(1, MIC_WRITE, 8'h10, 32'hBADBAD00);
        tick(3);
        exp_rd(0, 0, 32'hBADBAD00);
        exp_rd(1, 0, 32'hBADBAD00);
        exp_rd(2, 0, 32'h0000AAAA);
        put(0, MIC_READ, 8'h10, 32'h0);
        tick(4);

        // Reset in the cycle after the first read grant drops everything in flight
        exp_gnt(0, 1);
        exp_gnt(1, 0);
        exp_gnt(2, 1);
        for (int i = 0; i < N; i++) put(i, MIC_READ, ADR[i], 32'h0);
        tick(1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        for (int d = 0; d < NI; d++) begin
            check(!rdv[d] && full[d] == 0 && rv[d] == 0, $sformatf("mid_reset[%0d]", d),
                  {31'(0), rdv[d], 24'(0), full[d], rv[d]}, 64'(0));
        end
        tick(2);
        reset = 1'b0;
        for (int d = 0; d < NI; d++) begin
            for (int k = 0; k < 4; k++) exp_rd(d, k, DAT[k]);
        end
        for (int i = 0; i < N; i++) put(i, MIC_READ, ADR[i], 32'h0);
        tick(1);
        tick(10);

        for (int d = 0; d < NI; d++) begin
            check(gnt_q[d].size() == 0 && sb_q[d].size() == 0, $sformatf("leftover[%0d]", d),
                  {32'(gnt_q[d].size()), 32'(sb_q[d].size())}, 64'(0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
